// File: rtl/write_back_ctrl.sv
// Write-back stage: registers ALU/multiply results onto register-file ports and merges CPSR writes; 1-cycle latency.
// ready_o is low only during the hi-half cycle of a single-port long multiply; no other backpressure.
module write_back_ctrl #(
  parameter int              XLEN      = 32,
  parameter int              REG_IDX_W = 4,
  parameter int              WR_PORTS  = 1,
  parameter logic [XLEN-1:0] CPSR_RST  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [REG_IDX_W-1:0] dest_i,
  input  logic [REG_IDX_W-1:0] dest_hi_i,
  input  logic                 write_dest_do_i,
  input  logic                 write_dest_m_i,
  input  logic                 write_dest_ml_i,
  input  logic                 write_cpsr_i,
  input  logic [XLEN/8-1:0]    cpsr_mask_i,
  input  logic [XLEN-1:0]      result_i,
  input  logic [2*XLEN-1:0]    m_result_i,
  output logic                 we0_o,
  output logic [REG_IDX_W-1:0] rw_i0_o,
  output logic [XLEN-1:0]      rw0_o,
  output logic                 we1_o,
  output logic [REG_IDX_W-1:0] rw_i1_o,
  output logic [XLEN-1:0]      rw1_o,
  output logic [XLEN-1:0]      cpsr_o
);

  typedef enum logic {IDLE, HI} state_t;

  state_t               state_q, state_d;
  logic                 we0_q, we0_d, we1_q, we1_d;
  logic [REG_IDX_W-1:0] idx0_q, idx0_d, idx1_q, idx1_d;
  logic [XLEN-1:0]      dat0_q, dat0_d, dat1_q, dat1_d;
  logic [XLEN-1:0]      cpsr_q, cpsr_d;
  logic [REG_IDX_W-1:0] hi_idx_q, hi_idx_d;
  logic [XLEN-1:0]      hi_dat_q, hi_dat_d;
  logic                 accept;

  assign ready_o = (state_q == IDLE);
  assign accept  = valid_i && ready_o;

  always_comb begin
    state_d  = state_q;
    we0_d    = 1'b0;
    we1_d    = 1'b0;
    idx0_d   = idx0_q;
    dat0_d   = dat0_q;
    idx1_d   = idx1_q;
    dat1_d   = dat1_q;
    cpsr_d   = cpsr_q;
    hi_idx_d = hi_idx_q;
    hi_dat_d = hi_dat_q;

    if (state_q == HI) begin
      // Second half of a single-port long multiply; lands after lo so hi wins on equal indices.
      we0_d   = 1'b1;
      idx0_d  = hi_idx_q;
      dat0_d  = hi_dat_q;
      state_d = IDLE;
    end else if (accept) begin
      if (write_dest_do_i) begin
        we0_d  = 1'b1;
        idx0_d = dest_i;
        dat0_d = result_i;
      end else if (write_dest_m_i) begin
        we0_d  = 1'b1;
        idx0_d = dest_i;
        dat0_d = m_result_i[XLEN-1:0];
      end else if (write_dest_ml_i) begin
        if (WR_PORTS == 2) begin
          we1_d  = 1'b1;
          idx1_d = dest_hi_i;
          dat1_d = m_result_i[2*XLEN-1:XLEN];
          if (dest_i != dest_hi_i) begin
            we0_d  = 1'b1;
            idx0_d = dest_i;
            dat0_d = m_result_i[XLEN-1:0];
          end
        end else begin
          we0_d    = 1'b1;
          idx0_d   = dest_i;
          dat0_d   = m_result_i[XLEN-1:0];
          hi_idx_d = dest_hi_i;
          hi_dat_d = m_result_i[2*XLEN-1:XLEN];
          state_d  = HI;
        end
      end else if (write_cpsr_i) begin
        for (int k = 0; k < XLEN/8; k++) begin
          if (cpsr_mask_i[k]) cpsr_d[8*k +: 8] = result_i[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      we0_q    <= 1'b0;
      we1_q    <= 1'b0;
      idx0_q   <= '0;
      dat0_q   <= '0;
      idx1_q   <= '0;
      dat1_q   <= '0;
      cpsr_q   <= CPSR_RST;
      hi_idx_q <= '0;
      hi_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      we0_q    <= we0_d;
      we1_q    <= we1_d;
      idx0_q   <= idx0_d;
      dat0_q   <= dat0_d;
      idx1_q   <= idx1_d;
      dat1_q   <= dat1_d;
      cpsr_q   <= cpsr_d;
      hi_idx_q <= hi_idx_d;
      hi_dat_q <= hi_dat_d;
    end
  end

  assign we0_o   = we0_q;
  assign rw_i0_o = idx0_q;
  assign rw0_o   = dat0_q;
  assign we1_o   = (WR_PORTS == 2) ? we1_q  : 1'b0;
  assign rw_i1_o = (WR_PORTS == 2) ? idx1_q : '0;
  assign rw1_o   = (WR_PORTS == 2) ? dat1_q : '0;
  assign cpsr_o  = cpsr_q;

endmodule
